// File: rtl/gpsdo_loop_ctrl_if.sv
// DAC write port of the GPSDO disciplining loop: tuning word with a req/ack handshake.
interface gpsdo_loop_ctrl_if #(
    parameter int unsigned DAC_W = 16
);
    logic             DAC_Req;
    logic [DAC_W-1:0] DAC_Data;
    logic             DAC_Ack;

    modport master (output DAC_Req, output DAC_Data, input DAC_Ack);
    modport slave  (input DAC_Req, input DAC_Data, output DAC_Ack);
endinterface

// File: rtl/gpsdo_loop_ctrl.sv
// GPSDO disciplining loop: acquisition, averaging and PI update of the OCXO DAC word,
// with coarse-error realign requests and holdover while GPS is absent.
module gpsdo_loop_ctrl #(
    parameter int unsigned N_AVG     = 4,
    parameter int unsigned DAC_W     = 16,
    parameter int unsigned DAC_INIT  = 32768,
    parameter int unsigned KP_SHIFT  = 2,
    parameter int unsigned KI_SHIFT  = 4,
    parameter int unsigned COARSE_TH = 100,
    parameter int unsigned LOCK_TH   = 8
) (
    input  logic                      CLK_Sys,
    input  logic                      CLK_Rst,
    input  logic                      GPS_Exist,
    input  logic                      flag_cnt_phase_start,
    input  logic                      Flag_Measure_Dir,
    input  logic [15:0]               Phase_Out,
    gpsdo_loop_ctrl_if.master         dac,
    output logic                      Realign_Local,
    output logic                      Locked,
    output logic [2:0]                State
);
    localparam int unsigned ACC_W = 24;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned GOOD_W = 3;
    localparam logic [GOOD_W-1:0]   GOOD_MAX  = GOOD_W'(4);
    localparam logic signed [24:0]  INTEG_MAX = 25'sd8388607;
    localparam logic signed [24:0]  INTEG_MIN = -25'sd8388607;
    localparam logic signed [25:0]  DAC_INIT_S = 26'(DAC_INIT);
    localparam logic signed [25:0]  DAC_MAX_S  = 26'((64'd1 << DAC_W) - 64'd1);

    typedef enum logic [2:0] {
        ST_HOLD   = 3'd0,
        ST_ACQ    = 3'd1,
        ST_TRACK  = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DAC_WR = 3'd4
    } state_t;

    state_t                   r_state;
    logic                     r_f_d;
    logic                     r_meas_valid;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  r_integ;
    logic [CNT_W-1:0]         r_cnt;
    logic [GOOD_W-1:0]        r_good;
    logic                     r_dac_req;
    logic [DAC_W-1:0]         r_dac_data;
    logic                     r_realign;
    logic                     r_locked;

    logic signed [16:0]       w_err_pos;
    logic signed [16:0]       w_err;
    logic                     w_coarse;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic [CNT_W-1:0]         w_cnt_next;
    logic                     w_last;
    logic signed [24:0]       w_integ_sum;
    logic signed [ACC_W-1:0]  w_integ_new;
    logic signed [25:0]       w_dac_sum;
    logic [DAC_W-1:0]         w_dac_new;
    logic signed [24:0]       w_acc_ext;
    logic signed [24:0]       w_acc_abs;
    logic                     w_acc_good;

    // Signed error and coarse test; the magnitude is Phase_Out itself
    assign w_err_pos  = signed'({1'b0, Phase_Out});
    assign w_err      = Flag_Measure_Dir ? -w_err_pos : w_err_pos;
    assign w_coarse   = 32'(Phase_Out) > COARSE_TH;
    assign w_acc_next = r_acc + ACC_W'(w_err);
    assign w_cnt_next = r_cnt + CNT_W'(1);
    assign w_last     = 32'(w_cnt_next) == N_AVG;

    // PI step: saturating integrator, then proportional term and clamp to DAC range
    assign w_integ_sum = 25'(r_integ) + 25'(r_acc >>> KI_SHIFT);
    assign w_integ_new = (w_integ_sum > INTEG_MAX) ? ACC_W'(INTEG_MAX) :
                         (w_integ_sum < INTEG_MIN) ? ACC_W'(INTEG_MIN) :
                                                     ACC_W'(w_integ_sum);
    assign w_dac_sum   = DAC_INIT_S + 26'(w_integ_new) + 26'(r_acc >>> KP_SHIFT);
    assign w_dac_new   = (w_dac_sum < 26'sd0)     ? '0 :
                         (w_dac_sum > DAC_MAX_S)  ? DAC_W'(DAC_MAX_S) :
                                                    DAC_W'(w_dac_sum);

    assign w_acc_ext  = 25'(r_acc);
    assign w_acc_abs  = w_acc_ext[24] ? -w_acc_ext : w_acc_ext;
    assign w_acc_good = $unsigned(w_acc_abs) <= 25'(LOCK_TH);

    always_ff @(posedge CLK_Sys or negedge CLK_Rst) begin
        if (!CLK_Rst) begin
            r_state      <= ST_HOLD;
            r_f_d        <= 1'b0;
            r_meas_valid <= 1'b0;
            r_acc        <= '0;
            r_integ      <= '0;
            r_cnt        <= '0;
            r_good       <= '0;
            r_dac_req    <= 1'b0;
            r_dac_data   <= DAC_W'(DAC_INIT);
            r_realign    <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_f_d        <= flag_cnt_phase_start;
            r_meas_valid <= r_f_d & ~flag_cnt_phase_start;
            r_realign    <= 1'b0;
            case (r_state)
                ST_HOLD: begin
                    r_acc    <= '0;
                    r_cnt    <= '0;
                    r_good   <= '0;
                    r_locked <= 1'b0;
                    if (GPS_Exist) r_state <= ST_ACQ;
                end
                ST_ACQ: begin
                    if (!GPS_Exist) begin
                        r_locked <= 1'b0;
                        r_state  <= ST_HOLD;
                    end else if (r_meas_valid) begin
                        if (w_coarse) begin
                            r_realign <= 1'b1;
                        end else begin
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_state <= ST_TRACK;
                        end
                    end
                end
                ST_TRACK: begin
                    if (!GPS_Exist) begin
                        r_locked <= 1'b0;
                        r_state  <= ST_HOLD;
                    end else if (r_meas_valid) begin
                        if (w_coarse) begin
                            r_locked <= 1'b0;
                            r_good   <= '0;
                            r_state  <= ST_ACQ;
                        end else begin
                            r_acc <= w_acc_next;
                            r_cnt <= w_cnt_next;
                            if (w_last) r_state <= ST_UPDATE;
                        end
                    end
                end
                ST_UPDATE: begin
                    if (!GPS_Exist) begin
                        r_locked <= 1'b0;
                        r_state  <= ST_HOLD;
                    end else begin
                        r_integ    <= w_integ_new;
                        r_dac_data <= w_dac_new;
                        r_good     <= w_acc_good ? ((r_good == GOOD_MAX) ? GOOD_MAX : r_good + GOOD_W'(1))
                                                 : '0;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_dac_req  <= 1'b1;
                        r_state    <= ST_DAC_WR;
                    end
                end
                ST_DAC_WR: begin
                    // Handshake always completes before a GPS loss is honoured
                    if (dac.DAC_Ack) begin
                        r_dac_req <= 1'b0;
                        r_locked  <= GPS_Exist && (r_good == GOOD_MAX);
                        r_state   <= GPS_Exist ? ST_TRACK : ST_HOLD;
                    end
                end
                default: r_state <= ST_HOLD;
            endcase
        end
    end

    assign dac.DAC_Req   = r_dac_req;
    assign dac.DAC_Data  = r_dac_data;
    assign Realign_Local = r_realign;
    assign Locked        = r_locked;
    assign State         = r_state;
endmodule
